// File: rtl/ualfat_pkg.sv
// uALFAT command scheduler: shared encodings and helpers.
// Build option UALFAT_RESP_CHECK_EN selects response parsing over fixed gaps.
package ualfat_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_CMD  = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam logic [1:0] CMD_I = 2'd0;
  localparam logic [1:0] CMD_O = 2'd1;
  localparam logic [1:0] CMD_W = 2'd2;
  localparam logic [1:0] CMD_C = 2'd3;

  localparam logic [1:0] P_BANG = 2'd0;
  localparam logic [1:0] P_HI   = 2'd1;
  localparam logic [1:0] P_LO   = 2'd2;
  localparam logic [1:0] P_CR   = 2'd3;

  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] ERR_FMT = 8'hFE;
  localparam logic [7:0] ERR_TMO = 8'hFF;

  // Command text, left aligned in 12 character slots
  localparam logic [95:0] STR_I = {"I\r", 80'h0};
  localparam logic [95:0] STR_O = "O 1W>DA.LOG\r";
  localparam logic [95:0] STR_W = {"W 1>", 64'h0};
  localparam logic [95:0] STR_C = {"C 1\r", 64'h0};

  function automatic logic [7:0] hex_asc(logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [4:0] hex_val(logic [7:0] c);
    logic [4:0] v;
    v = '0;
    if (c >= 8'h30 && c <= 8'h39)
      v = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66))
      v = {1'b1, c[3:0] + 4'd9};
    return v;
  endfunction

  function automatic logic [3:0] cmd_last(logic [1:0] cmd);
    logic [3:0] n;
    unique case (cmd)
      CMD_I:   n = 4'd1;
      CMD_O:   n = 4'd11;
      CMD_W:   n = 4'd10;
      default: n = 4'd3;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] cmd_char(
    logic [1:0] cmd, logic [3:0] idx, logic [23:0] len);
    logic [7:0] c;
    int sh;
    sh = 8 * (11 - int'(idx));
    unique case (cmd)
      CMD_I: c = STR_I[sh +: 8];
      CMD_O: c = STR_O[sh +: 8];
      CMD_C: c = STR_C[sh +: 8];
      default: begin
        if (idx < 4'd4)
          c = STR_W[sh +: 8];
        else if (idx < 4'd10)
          c = hex_asc(len[4*(9-int'(idx)) +: 4]);
        else
          c = CH_CR;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ualfat_cmd_sched_if.sv
// Byte stream, response and control signals of the uALFAT scheduler.
interface ualfat_cmd_sched_if;
  logic       start;
  logic       byte_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] smp_data;
  logic       smp_valid;
  logic       smp_rd;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_code;

  modport master (
    output start, byte_ready, rx_byte, rx_valid,
    output smp_data, smp_valid,
    input  tx_byte, tx_valid, smp_rd,
    input  busy, done, err, err_code
  );

  modport slave (
    input  start, byte_ready, rx_byte, rx_valid,
    input  smp_data, smp_valid,
    output tx_byte, tx_valid, smp_rd,
    output busy, done, err, err_code
  );
endinterface

// File: rtl/ualfat_resp_parser.sv
// Parses "!HH\r" replies; bytes before '!' are dropped.
module ualfat_resp_parser
  import ualfat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       resp_done,
  output logic       resp_ok,
  output logic [7:0] resp_code
);

  logic [1:0] st_q, st_d;
  logic [7:0] val_q, val_d;
  logic [4:0] hv;

  always_comb begin
    hv = hex_val(rx_byte);
    st_d = st_q;
    val_d = val_q;
    resp_done = 1'b0;
    resp_ok = 1'b0;
    resp_code = ERR_FMT;
    if (clr) begin
      st_d = P_BANG;
    end else if (rx_valid) begin
      unique case (st_q)
        P_BANG: if (rx_byte == CH_BANG) st_d = P_HI;
        P_HI: begin
          val_d[7:4] = hv[3:0];
          st_d = hv[4] ? P_LO : P_BANG;
          resp_done = !hv[4];
        end
        P_LO: begin
          val_d[3:0] = hv[3:0];
          st_d = hv[4] ? P_CR : P_BANG;
          resp_done = !hv[4];
        end
        default: begin
          st_d = P_BANG;
          resp_done = 1'b1;
          if (rx_byte == CH_CR) begin
            resp_code = val_q;
            resp_ok = (val_q == 8'h00);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= P_BANG;
      val_q <= '0;
    end else begin
      st_q <= st_d;
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/ualfat_cmd_sched.sv
// Runs one uALFAT log session: I, O, W + data, C over the SPI byte engine.
// UALFAT_RESP_CHECK_EN: parse replies; otherwise wait GAP_CYC per reply.
module ualfat_cmd_sched
  import ualfat_pkg::*;
#(
  parameter logic [23:0] WR_LEN      = 24'd512,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000,
  parameter logic [15:0] GAP_CYC     = 16'd50000
) (
  input logic clk,
  input logic rst,
  ualfat_cmd_sched_if.slave io
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [3:0]  chr_q, chr_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic        post_q, post_d;
  logic        err_q, err_d;
  logic [7:0]  code_q, code_d;

  logic       busy;
  logic       tmr_clr;
  logic       resp_go;
  logic       resp_bad;
  logic [7:0] bad_code;

  assign busy = (state_q == ST_SEND_CMD) ||
                (state_q == ST_WAIT_RESP) ||
                (state_q == ST_SEND_DATA);

`ifdef UALFAT_RESP_CHECK_EN
  logic       rx_en;
  logic       resp_done;
  logic       resp_ok;
  logic [7:0] resp_code;
  logic       unused_gap;

  assign unused_gap = ^GAP_CYC;
  assign rx_en = io.rx_valid && (state_q == ST_WAIT_RESP);

  ualfat_resp_parser u_parser (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != ST_WAIT_RESP),
    .rx_byte   (io.rx_byte),
    .rx_valid  (rx_en),
    .resp_done (resp_done),
    .resp_ok   (resp_ok),
    .resp_code (resp_code)
  );

  // Any received byte restarts the timeout window
  assign tmr_clr  = rx_en;
  assign resp_go  = resp_done && resp_ok;
  assign resp_bad = resp_done ? !resp_ok
                  : (!rx_en && (tmr_q + 32'd1 >= TIMEOUT_CYC));
  assign bad_code = resp_done ? resp_code : ERR_TMO;
`else
  logic unused_chk;

  assign unused_chk = ^{io.rx_byte, io.rx_valid, TIMEOUT_CYC};
  assign tmr_clr  = 1'b0;
  assign resp_go  = (tmr_q + 32'd1 >= {16'h0, GAP_CYC});
  assign resp_bad = 1'b0;
  assign bad_code = ERR_TMO;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    chr_d = chr_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    post_d = post_q;
    err_d = err_q;
    code_d = code_q;
    unique case (state_q)
      ST_SEND_CMD: begin
        if (io.byte_ready) begin
          if (chr_q == cmd_last(cmd_q)) begin
            state_d = ST_WAIT_RESP;
            chr_d = '0;
            tmr_d = '0;
          end else begin
            chr_d = chr_q + 4'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        tmr_d = tmr_clr ? '0 : tmr_q + 32'd1;
        if (resp_bad) begin
          state_d = ST_ERROR;
          err_d = 1'b1;
          code_d = bad_code;
        end else if (resp_go) begin
          tmr_d = '0;
          unique case (cmd_q)
            CMD_W: begin
              // W gets a reply before and after its data block
              if (post_q) begin
                cmd_d = CMD_C;
                post_d = 1'b0;
                state_d = ST_SEND_CMD;
              end else if (WR_LEN == 24'd0) begin
                post_d = 1'b1;
              end else begin
                state_d = ST_SEND_DATA;
                cnt_d = '0;
              end
            end
            CMD_C: state_d = ST_DONE;
            default: begin
              cmd_d = cmd_q + 2'd1;
              state_d = ST_SEND_CMD;
            end
          endcase
        end
      end
      ST_SEND_DATA: begin
        if (io.smp_valid && io.byte_ready) begin
          cnt_d = cnt_q + 24'd1;
          if (cnt_q == WR_LEN - 24'd1) begin
            state_d = ST_WAIT_RESP;
            post_d = 1'b1;
            tmr_d = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    if (io.start && !busy) begin
      state_d = ST_SEND_CMD;
      cmd_d = CMD_I;
      chr_d = '0;
      cnt_d = '0;
      tmr_d = '0;
      post_d = 1'b0;
      err_d = 1'b0;
      code_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q <= CMD_I;
      chr_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      post_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      chr_q <= chr_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      post_q <= post_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end

  always_comb begin
    io.tx_byte = '0;
    io.tx_valid = 1'b0;
    io.smp_rd = 1'b0;
    unique case (state_q)
      ST_SEND_CMD: begin
        io.tx_byte = cmd_char(cmd_q, chr_q, WR_LEN);
        io.tx_valid = 1'b1;
      end
      ST_SEND_DATA: begin
        io.tx_byte = io.smp_data;
        io.tx_valid = io.smp_valid;
        io.smp_rd = io.smp_valid && io.byte_ready;
      end
      default: ;
    endcase
  end

  assign io.busy = busy;
  assign io.done = (state_q == ST_DONE);
  assign io.err = err_q;
  assign io.err_code = code_q;

endmodule

// File: tb/tb_ualfat_cmd_sched.sv
// Scoreboard bench for ualfat_cmd_sched (WR_LEN=4, TIMEOUT=100, GAP=8).
// Expected outcomes follow UALFAT_RESP_CHECK_EN when it is defined.
module tb_ualfat_cmd_sched;

`ifdef UALFAT_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int R_NONE = 0;
  localparam int R_OK   = 1;
  localparam int R_JUNK = 2;
  localparam int R_C3   = 3;

  typedef struct {
    logic [7:0] b;
    bit         d;
    int         r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ualfat_cmd_sched_if io ();

  ualfat_cmd_sched #(
    .WR_LEN      (24'd4),
    .TIMEOUT_CYC (32'd100),
    .GAP_CYC     (16'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] fifo[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int done_cnt = 0;
  int stall_left = 0;
  bit stall_arm = 0;
  bit toggle = 0;

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected event", nm);
  endfunction

  function automatic string resp_str(int k);
    case (k)
      R_OK:    return "!00\r";
      R_JUNK:  return "Z!00\r";
      R_C3:    return "!C3\r";
      default: return "";
    endcase
  endfunction

  function automatic logic [20:0] outs();
    return {io.tx_byte, io.tx_valid, io.smp_rd, io.busy,
            io.done, io.err, io.err_code};
  endfunction

  always @(posedge clk) cyc++;

  // Sample-FIFO model, byte_ready pattern and stall window
  always @(posedge clk) begin
    #1;
    io.byte_ready = toggle ? ~io.byte_ready : 1'b1;
    if (stall_arm && fifo.size() == 2) begin
      stall_left = 20;
      stall_arm = 0;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    io.smp_valid = (fifo.size() > 0) && (stall_left == 0);
    io.smp_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // uALFAT reply generator, one byte per cycle
  always @(posedge clk) begin
    #1;
    if (rsp_q.size() > 0) begin
      io.rx_valid = 1'b1;
      io.rx_byte = rsp_q.pop_front();
    end else begin
      io.rx_valid = 1'b0;
      io.rx_byte = 8'h00;
    end
  end

  // Monitor: compare every transfer against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    string s;
    if (io.tx_valid && io.byte_ready) begin
      xfer_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {24'h0, io.tx_byte}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", io.tx_byte, e.b);
        check("smp_rd", io.smp_rd, e.d);
        s = resp_str(e.r);
        for (int i = 0; i < s.len(); i++)
          rsp_q.push_back(s[i]);
      end
    end
    if (io.smp_rd && fifo.size() > 0)
      void'(fifo.pop_front());
    if (io.done) done_cnt++;
    if (stall_left > 0)
      check("stall_quiet", {io.tx_valid, io.smp_rd}, 0);
  end

  task automatic push_b(logic [7:0] b, bit d, int r);
    exp_t e;
    e.b = b;
    e.d = d;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic push_str(string s, int r);
    for (int i = 0; i < s.len(); i++)
      push_b(s[i], 1'b0, (i == s.len() - 1) ? r : R_NONE);
  endtask

  task automatic push_session(int i_resp, int o_resp);
    logic [7:0] dat [4];
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_str("I\r", i_resp);
    if (CHK && i_resp == R_NONE) return;
    push_str("O 1W>DA.LOG\r", o_resp);
    if (CHK && o_resp == R_C3) return;
    push_str("W 1>000004\r", R_OK);
    for (int k = 0; k < 4; k++)
      push_b(dat[k], 1'b1, (k == 3) ? R_JUNK : R_NONE);
    push_str("C 1\r", R_OK);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 io.start = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
  endtask

  task automatic run(string nm, int i_resp, int o_resp,
                     bit tog, bit stl, bit x_err,
                     logic [7:0] x_code, int x_done);
    int d0;
    int err_cyc;
    bit fin;
    d0 = done_cnt;
    err_cyc = -1;
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
    toggle = tog;
    stall_arm = stl;
    push_session(i_resp, o_resp);
    pulse_start();
    @(negedge clk);
    check({nm, "_busy"}, io.busy, 1);
    check({nm, "_err_clr"}, io.err, 0);
    fin = 0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      @(negedge clk);
      if (io.err) err_cyc = cyc;
      if (io.err || done_cnt != d0) fin = 1;
    end
    if (!fin) fail({nm, "_end"});
    if (io.err && io.err_code == 8'hFF)
      check({nm, "_tmo_cyc"}, err_cyc - xfer_cyc, 100);
    toggle = 0;
    repeat (20) @(negedge clk);
    check({nm, "_drained"}, exp_q.size(), 0);
    check({nm, "_done"}, done_cnt - d0, x_done);
    check({nm, "_err"}, io.err, x_err);
    check({nm, "_code"}, io.err_code, x_code);
    check({nm, "_idle"}, io.busy, 0);
  endtask

  initial begin
    io.start = 1'b0;
    io.byte_ready = 1'b1;
    io.rx_byte = 8'h00;
    io.rx_valid = 1'b0;
    io.smp_data = 8'h00;
    io.smp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    run("basic", R_OK, R_OK, 0, 0, 0, 8'h00, 1);
    run("toggle", R_OK, R_JUNK, 1, 0, 0, 8'h00, 1);
    run("c3", R_OK, R_C3, 0, 0, CHK,
        CHK ? 8'hC3 : 8'h00, CHK ? 0 : 1);
    run("stall", R_OK, R_OK, 0, 1, 0, 8'h00, 1);
    run("tmo", R_NONE, R_OK, 0, 0, CHK,
        CHK ? 8'hFF : 8'h00, CHK ? 0 : 1);

    // Reset in the middle of the data block
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_session(R_OK, R_OK);
    pulse_start();
    for (int n = 0; n < 500 && fifo.size() > 2; n++)
      @(negedge clk);
    if (fifo.size() > 2) fail("rst_reach_data");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_mid_outs", outs(), 0);
    exp_q.delete();
    rsp_q.delete();
    fifo.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_after_outs", outs(), 0);
    run("post_rst", R_OK, R_OK, 0, 0, 0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ualfat_cmd_sched.md
UALFAT_CMD_SCHED -- requirements
Module: ualfat_cmd_sched

Interface
REQ-001 SHALL have parameter WR_LEN, default 24'd512: byte count of one logged data record.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32'd1000000: maximum cycles to wait for a uALFAT response.
REQ-003 SHALL have parameter GAP_CYC, default 16'd50000: fixed inter-command gap, used only when response checking is compiled out.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to run one full log session.
REQ-007 byte_ready  in  1  SPI byte engine can accept a byte.
REQ-008 tx_byte  out  8  byte offered to the SPI byte engine.
REQ-009 tx_valid  out  1  tx_byte is valid; a transfer occurs on a cycle with tx_valid && byte_ready.
REQ-010 rx_byte  in  8  byte received from uALFAT.
REQ-011 rx_valid  in  1  rx_byte valid, one-cycle strobe.
REQ-012 smp_data  in  8  sample byte from the acquisition FIFO.
REQ-013 smp_valid  in  1  smp_data available.
REQ-014 smp_rd  out  1  FIFO pop; high exactly on cycles a sample byte transfers.
REQ-015 busy  out  1  session in progress.
REQ-016 done  out  1  one-cycle pulse on successful session end.
REQ-017 err  out  1  sticky error flag, cleared by the next accepted start.
REQ-018 err_code  out  8  uALFAT status byte pair value, or 8'hFF on timeout.

Function
REQ-019 States: IDLE, SEND_CMD, WAIT_RESP, SEND_DATA, DONE, ERROR.
REQ-020 A session sends, in order: "I\r"; "O 1W>DA.LOG\r"; "W 1>" plus WR_LEN as 6 uppercase hex digits plus "\r"; WR_LEN sample bytes; "C 1\r".
REQ-021 start in IDLE, DONE or ERROR SHALL begin a session on the next cycle; start while busy SHALL be ignored.
REQ-022 In SEND_CMD, tx_byte SHALL hold the current command character and advance only on a transfer cycle; tx_valid SHALL be high continuously.
REQ-023 After the last character ("\r") of each command transfers, the FSM SHALL enter WAIT_RESP.
REQ-024 A response is '!', two hex digits, '\r'; "!00" SHALL mean success, otherwise enter ERROR with err_code = parsed value (e.g. "!C3" -> 8'hC3).
REQ-025 Non-'!' bytes before '!' SHALL be discarded; a non-hex digit or missing '\r' SHALL give ERROR with err_code 8'hFE.
REQ-026 The W command expects two responses: one before SEND_DATA and one after the last data byte.
REQ-027 In SEND_DATA, tx_byte = smp_data and tx_valid = smp_valid; an empty FIFO SHALL stall without error or timeout.
REQ-028 The data counter SHALL be 24 bits; SEND_DATA ends when exactly WR_LEN bytes have transferred; WR_LEN = 0 SHALL skip SEND_DATA.
REQ-029 The WAIT_RESP timer SHALL reset on every rx_valid; reaching TIMEOUT_CYC SHALL give ERROR with err_code 8'hFF.
REQ-030 After the C 1 response succeeds, the FSM SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-031 tx_valid and smp_rd SHALL be low in IDLE, WAIT_RESP, DONE and ERROR.
REQ-032 rx_valid outside WAIT_RESP SHALL be ignored.

Reset
REQ-033 rst SHALL immediately force IDLE, tx_byte=0, tx_valid=0, smp_rd=0, busy=0, done=0, err=0, err_code=0, and clear all counters, including when asserted mid-transfer.

Configuration
REQ-034 Macro UALFAT_RESP_CHECK_EN defined: WAIT_RESP parses responses per REQ-024..REQ-029.
REQ-035 Macro undefined: WAIT_RESP waits exactly GAP_CYC cycles, ignores rx inputs, never sets err; the parser is not instantiated.

Structure
REQ-036 Package ualfat_pkg SHALL hold the state encoding, the command character constants, and the error codes 8'hFE and 8'hFF.
REQ-037 The response parser SHALL be a sub-module ualfat_resp_parser with outputs resp_done, resp_ok and resp_code[7:0].

Verification
REQ-038 With WR_LEN=4, byte_ready=1, all responses "!00\r", and FIFO bytes 11,22,33,44: the tx stream matches REQ-020 with "W 1>000004\r", then done pulses once.
REQ-039 Responding "!C3\r" to the O command -> err=1, err_code=8'hC3, W never sent; a later start clears err.
REQ-040 Giving no response after "I\r" for TIMEOUT_CYC=100 cycles -> err=1, err_code=8'hFF at cycle 100.
REQ-041 Holding smp_valid low for 20 cycles mid-data -> tx_valid=0, smp_rd=0, no error, and the byte count is still exactly WR_LEN.
REQ-042 Toggling byte_ready 1/0 each cycle -> each character is sent once and none are dropped.
REQ-043 Asserting rst during SEND_DATA -> all outputs at reset values in the same cycle; the next start begins with "I\r".
